// File: rtl/lx32_isa_pkg.sv
// LX32 ISA package: RV32I opcode constants, control-sequencer state and
// datapath-select encodings, plus the opcode legality check shared by the
// decoder and anything else that needs to know what the core executes.
package lx32_isa_pkg;

    // RV32I major opcodes understood by the multi-cycle core
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    // All-zero instruction word is never a legal encoding
    localparam logic [6:0] OP_INVALID = 7'b0000000;

    // Nine sequencer states, hence four bits
    typedef enum logic [3:0] {
        RESET      = 4'd0,
        FETCH      = 4'd1,
        FETCH_WAIT = 4'd2,
        DECODE     = 4'd3,
        EXECUTE    = 4'd4,
        MEM        = 4'd5,
        MEM_WAIT   = 4'd6,
        WB         = 4'd7,
        TRAP       = 4'd8
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

    // True for every major opcode the sequencer knows how to execute
    function automatic logic is_valid_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: is_valid_opcode = 1'b1;
            default:                          is_valid_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lx32_ctrl_decode.sv
// LX32 control decoder: purely combinational opcode -> datapath-select map.
// Unknown opcodes decode to all-zero selects with valid_o low, so a NOP
// retirement naturally writes nothing and advances by pc+4.
module lx32_ctrl_decode
    import lx32_isa_pkg::*;
(
    input  logic [6:0] opcode_i,
    output alu_a_sel_t alu_a_sel_o,
    output logic       alu_b_sel_o,
    output wb_sel_t    wb_sel_o,
    output pc_sel_t    jump_pc_sel_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_branch_o,
    output logic       writes_rd_o,
    output logic       valid_o
);

    // Opcode class decode; defaults describe a harmless NOP
    always_comb begin
        alu_a_sel_o   = ALU_A_RS1;
        alu_b_sel_o   = 1'b0;
        wb_sel_o      = WB_ALU;
        jump_pc_sel_o = PC_PLUS4;
        is_load_o     = 1'b0;
        is_store_o    = 1'b0;
        is_branch_o   = 1'b0;
        writes_rd_o   = 1'b0;
        valid_o       = is_valid_opcode(opcode_i);
        case (opcode_i)
            OP_OP: begin
                writes_rd_o = 1'b1;
            end
            OP_IMM: begin
                alu_b_sel_o = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_LOAD: begin
                alu_b_sel_o = 1'b1;
                wb_sel_o    = WB_LOAD;
                is_load_o   = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_STORE: begin
                alu_b_sel_o = 1'b1;
                is_store_o  = 1'b1;
            end
            OP_BRANCH: begin
                is_branch_o = 1'b1;
            end
            OP_JAL: begin
                // Target comes from the pc+imm adder; ALU set up the same way
                alu_a_sel_o   = ALU_A_PC;
                alu_b_sel_o   = 1'b1;
                wb_sel_o      = WB_PC4;
                jump_pc_sel_o = PC_IMM;
                writes_rd_o   = 1'b1;
            end
            OP_JALR: begin
                alu_b_sel_o   = 1'b1;
                wb_sel_o      = WB_PC4;
                jump_pc_sel_o = PC_ALU;
                writes_rd_o   = 1'b1;
            end
            OP_AUIPC: begin
                alu_a_sel_o = ALU_A_PC;
                alu_b_sel_o = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_LUI: begin
                alu_a_sel_o = ALU_A_ZERO;
                alu_b_sel_o = 1'b1;
                writes_rd_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lx32_ctrl_fsm.sv
// LX32 multi-cycle control sequencer. Owns the state register and drives
// IR/PC/ALU/RF/memory-port controls from the registered state plus the
// opcode held in the instruction register. gnt/rvalid-qualified pulses
// (ir_we, store retire) use the handshake inputs in the same cycle.
// Optional build macro LX32_CTRL_PERF_EN adds cycle/instret counters.
module lx32_ctrl_fsm
    import lx32_isa_pkg::*;
#(
    parameter bit TRAP_ON_INVALID = 1'b1
`ifdef LX32_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode_i,
    input  logic             branch_taken_i,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_is_fetch_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic [1:0]       alu_a_sel_o,
    output logic             alu_b_sel_o,
    output logic             rf_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             retire_o,
    output logic             illegal_o,
    output logic [3:0]       state_o
`ifdef LX32_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o
`endif
);

    ctrl_state_t state_q, state_d;

    alu_a_sel_t dec_alu_a;
    logic       dec_alu_b;
    wb_sel_t    dec_wb_sel;
    pc_sel_t    dec_jump_pc_sel;
    logic       dec_is_load, dec_is_store, dec_is_branch;
    logic       dec_writes_rd, dec_valid;

    lx32_ctrl_decode u_decode (
        .opcode_i      (opcode_i),
        .alu_a_sel_o   (dec_alu_a),
        .alu_b_sel_o   (dec_alu_b),
        .wb_sel_o      (dec_wb_sel),
        .jump_pc_sel_o (dec_jump_pc_sel),
        .is_load_o     (dec_is_load),
        .is_store_o    (dec_is_store),
        .is_branch_o   (dec_is_branch),
        .writes_rd_o   (dec_writes_rd),
        .valid_o       (dec_valid)
    );

    // State register; rst drops straight back to RESET mid-transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RESET;
        else     state_q <= state_d;
    end

    // Next-state sequencing; only the memory states wait on handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:      state_d = FETCH;
            FETCH:      if (mem_gnt_i) state_d = FETCH_WAIT;
            FETCH_WAIT: if (mem_rvalid_i) state_d = DECODE;
            DECODE: begin
                if (dec_valid)            state_d = EXECUTE;
                else if (TRAP_ON_INVALID) state_d = TRAP;
                else                      state_d = WB;
            end
            EXECUTE: begin
                if (dec_is_branch)                   state_d = FETCH;
                else if (dec_is_load || dec_is_store) state_d = MEM;
                else                                 state_d = WB;
            end
            MEM:        if (mem_gnt_i) state_d = dec_is_store ? FETCH : MEM_WAIT;
            MEM_WAIT:   if (mem_rvalid_i) state_d = WB;
            WB:         state_d = FETCH;
            TRAP:       state_d = TRAP;
            default:    state_d = RESET;
        endcase
    end

    // Output decode; ALU selects stay put from EXECUTE to WB so JALR's
    // pc_sel=ALU sees a settled result
    always_comb begin
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_is_fetch_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_sel_o       = PC_PLUS4;
        alu_a_sel_o    = ALU_A_RS1;
        alu_b_sel_o    = 1'b0;
        rf_we_o        = 1'b0;
        wb_sel_o       = WB_ALU;
        retire_o       = 1'b0;
        illegal_o      = 1'b0;
        if (state_q inside {EXECUTE, MEM, MEM_WAIT, WB}) begin
            alu_a_sel_o = dec_alu_a;
            alu_b_sel_o = dec_alu_b;
        end
        case (state_q)
            FETCH: begin
                mem_req_o      = 1'b1;
                mem_is_fetch_o = 1'b1;
            end
            FETCH_WAIT: ir_we_o = mem_rvalid_i;
            EXECUTE: begin
                if (dec_is_branch) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = branch_taken_i ? PC_IMM : PC_PLUS4;
                    retire_o = 1'b1;
                end
            end
            MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = dec_is_store;
                if (dec_is_store && mem_gnt_i) begin
                    pc_we_o  = 1'b1;
                    retire_o = 1'b1;
                end
            end
            WB: begin
                rf_we_o  = dec_writes_rd;
                wb_sel_o = dec_wb_sel;
                pc_we_o  = 1'b1;
                pc_sel_o = dec_jump_pc_sel;
                retire_o = 1'b1;
            end
            TRAP: illegal_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

`ifdef LX32_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

    // Free-running counters, frozen in RESET and TRAP, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != RESET && state_q != TRAP) cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (retire_o) instret_cnt_q <= instret_cnt_q + 1'b1;
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
`endif

endmodule

// File: tb/tb_lx32_ctrl_fsm.sv
// Bench for lx32_ctrl_fsm: randomized instruction stream with a reactive
// memory responder, expectations queued at issue and checked at retire.
`timescale 1ns/1ps
module tb_lx32_ctrl_fsm;
    import lx32_isa_pkg::*;

    localparam int N_INST = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT (trap on invalid)
    logic [6:0] opcode;
    logic       taken, gnt, rvalid;
    logic       mem_req, mem_we, mem_is_fetch, ir_we, pc_we, alu_b, rf_we, retire, illegal;
    logic [1:0] pc_sel, alu_a, wb_sel;
    logic [3:0] state;
    // NOP-retiring DUT
    logic       n_gnt, n_rv;
    logic       n_req, n_we, n_fetch, n_ir_we, n_pc_we, n_alu_b, n_rf_we, n_retire, n_illegal;
    logic [1:0] n_pc_sel, n_alu_a, n_wb_sel;
    logic [3:0] n_state;
`ifdef LX32_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ins_cnt, n_cyc_cnt, n_ins_cnt;
`endif

    lx32_ctrl_fsm #(.TRAP_ON_INVALID(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode_i(opcode), .branch_taken_i(taken),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_is_fetch_o(mem_is_fetch), .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
        .alu_a_sel_o(alu_a), .alu_b_sel_o(alu_b), .rf_we_o(rf_we), .wb_sel_o(wb_sel),
        .retire_o(retire), .illegal_o(illegal), .state_o(state)
`ifdef LX32_CTRL_PERF_EN
        , .cycle_cnt_o(cyc_cnt), .instret_cnt_o(ins_cnt)
`endif
    );

    lx32_ctrl_fsm #(.TRAP_ON_INVALID(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .opcode_i(OP_INVALID), .branch_taken_i(1'b0),
        .mem_gnt_i(n_gnt), .mem_rvalid_i(n_rv), .mem_req_o(n_req), .mem_we_o(n_we),
        .mem_is_fetch_o(n_fetch), .ir_we_o(n_ir_we), .pc_we_o(n_pc_we), .pc_sel_o(n_pc_sel),
        .alu_a_sel_o(n_alu_a), .alu_b_sel_o(n_alu_b), .rf_we_o(n_rf_we), .wb_sel_o(n_wb_sel),
        .retire_o(n_retire), .illegal_o(n_illegal), .state_o(n_state)
`ifdef LX32_CTRL_PERF_EN
        , .cycle_cnt_o(n_cyc_cnt), .instret_cnt_o(n_ins_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        logic [6:0] op;
        int         lat;
        logic [1:0] pcs;
        bit         wr;
        logic [1:0] wbs;
        bit         chk_alu;
        logic [1:0] a;
        logic       b;
        int         start;
    } exp_t;

    exp_t exp_q[$];

    // Expected retirement behaviour from the instruction-class rules.
    // fg = fetch gnt wait, fr = fetch gnt->rvalid distance, mg/mr for data.
    function automatic exp_t model(input logic [6:0] op, input bit tk, input int fg, input int fr,
                                   input int mg, input int mr, input int start);
        exp_t e;
        e.op = op; e.start = start; e.pcs = 2'd0; e.wr = 1'b1; e.wbs = 2'd0;
        e.chk_alu = 1'b1; e.a = 2'd0; e.b = 1'b1;
        e.lat = 5 + fg + (fr - 1);
        case (op)
            OP_OP:     e.b = 1'b0;
            OP_LUI:    e.a = 2'd2;
            OP_AUIPC:  e.a = 2'd1;
            OP_JAL:    begin e.chk_alu = 1'b0; e.pcs = 2'd1; e.wbs = 2'd2; end
            OP_JALR:   begin e.pcs = 2'd2; e.wbs = 2'd2; end
            OP_BRANCH: begin e.b = 1'b0; e.wr = 1'b0; e.pcs = tk ? 2'd1 : 2'd0; e.lat = e.lat - 1; end
            OP_STORE:  begin e.wr = 1'b0; e.lat = e.lat + mg; end
            OP_LOAD:   begin e.wbs = 2'd1; e.lat = e.lat + 2 + mg + (mr - 1); end
            default: ;
        endcase
        return e;
    endfunction

    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Scoreboard monitor for the main DUT
    int ir_cnt = 0, pcwe_cnt = 0, rfwe_cnt = 0, retired = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ir_we) ir_cnt++;
            if (pc_we) pcwe_cnt++;
            if (rf_we) rfwe_cnt++;
            if (retire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("latency_op%0h", e.op), cyc - e.start + 1, e.lat);
                    chk($sformatf("pc_sel_op%0h", e.op), pc_sel, e.pcs);
                    chk($sformatf("ir_we_count_op%0h", e.op), ir_cnt, 1);
                    chk($sformatf("pc_we_count_op%0h", e.op), pcwe_cnt, 1);
                    chk($sformatf("rf_we_count_op%0h", e.op), rfwe_cnt, e.wr);
                    if (e.wr) chk($sformatf("wb_sel_op%0h", e.op), wb_sel, e.wbs);
                    if (e.chk_alu) begin
                        chk($sformatf("alu_a_op%0h", e.op), alu_a, e.a);
                        chk($sformatf("alu_b_op%0h", e.op), alu_b, e.b);
                    end
`ifdef LX32_CTRL_PERF_EN
                    chk("cycle_cnt", cyc_cnt, cyc - 1);
                    chk("instret_cnt", ins_cnt, retired);
`endif
                end
                retired++;
                $display("retire #%0d cyc=%0d pc_sel=%0d rf_we_seen=%0d wb_sel=%0d", retired, cyc, pc_sel, rfwe_cnt, wb_sel);
                ir_cnt = 0; pcwe_cnt = 0; rfwe_cnt = 0;
            end
        end
    end

    // Zero-wait responder for the NOP DUT: gnt in the request cycle, rvalid next
    bit n_pend = 1'b0;
    initial begin
        n_gnt = 1'b0; n_rv = 1'b0;
        forever begin
            @(posedge clk); #1;
            n_rv = n_pend;
            n_pend = 1'b0;
            n_gnt = n_req;
            if (n_req && !n_we) n_pend = 1'b1;
        end
    end

    int n_retired = 0;
    always @(negedge clk) begin
        if (!rst && n_retire) begin
            chk("nop_pc_sel", n_pc_sel, 0);
            chk("nop_rf_we", n_rf_we, 0);
            chk("nop_pc_we", n_pc_we, 1);
            chk("nop_illegal", n_illegal, 0);
            n_retired++;
        end
    end

    // Stimulus plus reactive memory responder for the main DUT
    logic [6:0] dir_op [7];
    bit         dir_tk [7];
    logic [6:0] rnd_op [9];
    int fg = 0, fr = 1, mg = 0, mr = 1;
    int rq_cnt = 0, rv_left = 0, n_issued = 0, trap_start = 0, mreq = 0;
    bit issued = 1'b0, trap_issued = 1'b0, done = 1'b0;

    initial begin
        dir_op[0] = OP_OP;     dir_op[1] = OP_IMM;    dir_op[2] = OP_LUI;
        dir_op[3] = OP_LOAD;   dir_op[4] = OP_BRANCH; dir_op[5] = OP_BRANCH;
        dir_op[6] = OP_JALR;
        dir_tk[0] = 0; dir_tk[1] = 0; dir_tk[2] = 0; dir_tk[3] = 0;
        dir_tk[4] = 1; dir_tk[5] = 0; dir_tk[6] = 0;
        rnd_op[0] = OP_OP;   rnd_op[1] = OP_IMM;   rnd_op[2] = OP_LUI;
        rnd_op[3] = OP_AUIPC; rnd_op[4] = OP_JAL;  rnd_op[5] = OP_JALR;
        rnd_op[6] = OP_BRANCH; rnd_op[7] = OP_LOAD; rnd_op[8] = OP_STORE;

        opcode = OP_OP; taken = 1'b0; gnt = 1'b1; rvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel, alu_a, alu_b,
                              rf_we, wb_sel, retire, illegal}, 0);
        chk("reset_state", state, 0);
        gnt = 1'b0; rvalid = 1'b0;
        rst = 1'b0;
        #1;
        chk("release_no_req", mem_req, 0);

        for (int k = 0; k < 5000 && !done; k++) begin
            @(posedge clk); #1;
            if (cyc == 1) chk("first_fetch_req", mem_req, 1);
            if (state == FETCH) begin
                if (!issued) begin
                    issued = 1'b1;
                    if (n_issued < N_INST) begin
                        if (n_issued < 7) begin
                            opcode = dir_op[n_issued]; taken = dir_tk[n_issued];
                            fg = 0; fr = 1;
                            mg = (n_issued == 3) ? 3 : 0;
                            mr = (n_issued == 3) ? 2 : 1;
                        end else begin
                            opcode = rnd_op[$urandom_range(0, 8)];
                            taken = 1'($urandom_range(0, 1));
                            fg = $urandom_range(0, 3); fr = $urandom_range(1, 3);
                            mg = $urandom_range(0, 3); mr = $urandom_range(1, 3);
                        end
                        exp_q.push_back(model(opcode, taken, fg, fr, mg, mr, cyc));
                        n_issued++;
                    end else if (!trap_issued) begin
                        opcode = OP_INVALID; fg = 0; fr = 1;
                        trap_issued = 1'b1; trap_start = cyc;
                    end
                end
            end else begin
                issued = 1'b0;
            end
            if (trap_issued && illegal) begin
                chk("trap_latency", cyc - trap_start, 3);
                done = 1'b1;
            end
            // responder: rvalid a fixed distance after a read gnt, else spurious
            gnt = 1'b0; rvalid = 1'b0;
            if (rv_left > 0) begin
                rv_left--;
                if (rv_left == 0) rvalid = 1'b1;
            end else begin
                rvalid = ($urandom_range(0, 3) == 0);
            end
            if (mem_req) begin
                if (rq_cnt == (mem_is_fetch ? fg : mg)) begin
                    gnt = 1'b1; rq_cnt = 0;
                    if (!mem_we) rv_left = mem_is_fetch ? fr : mr;
                end else begin
                    rq_cnt++;
                end
            end else begin
                gnt = ($urandom_range(0, 3) == 0);
            end
        end
        chk("run_completed", done, 1);
        chk("all_retired", retired, N_INST);
        chk("queue_drained", exp_q.size(), 0);

        // TRAP must be silent and sticky despite stray handshakes
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            gnt = 1'($urandom_range(0, 1)); rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (mem_req) mreq++;
            chk("trap_sticky", illegal, 1);
        end
        chk("trap_no_req", mreq, 0);
        chk("nop_retires_seen", n_retired > 0, 1);

        // asynchronous reset mid-cycle clears everything without a clock edge
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_illegal", illegal, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_outputs", {mem_req, ir_we, pc_we, rf_we, retire, n_req, n_retire}, 0);
`ifdef LX32_CTRL_PERF_EN
        chk("async_rst_cycle_cnt", cyc_cnt, 0);
        chk("async_rst_instret_cnt", ins_cnt, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
